// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the Jac1-8 core.
// Owns the program counter, captures the registered Program_Mem read and
// offers each instruction to the decoder. It also handles execute-stage jump
// redirects, run/stop control and a wrapping count of delivered instructions.
//
// Decoder handshake: instr_o is offered while instr_valid_o=1. A transfer
// happens on a rising edge where instr_valid_o=1 and instr_ready_i=1. Until
// that transfer, instr_o stays stable. A jump may withdraw an offer that has
// not been transferred, and that offer is never counted.
module fetch_ctrl #(
  parameter int                  PC_WIDTH  = 8,
  parameter int                  DataWidth = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 run_i,
  input  logic                 stop_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  input  logic [DataWidth-1:0] ir_i,
  output logic [DataWidth-1:0] instr_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  jump_addr_i,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] fetch_count_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_OFFER   = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 xfer;
  logic                 start_ok;

  assign xfer     = valid_q & instr_ready_i;
  // Stop wins over run when both are requested together.
  assign start_ok = run_i & ~stop_i;

  // Next-state logic: sequencing, handshake, stop latching and jump redirect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD, S_CAPTURE, S_OFFER: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (state_q == S_LOAD) begin
          // Memory registers mem[pc] on this edge; its output is usable next cycle.
          state_d = S_CAPTURE;
        end else if (state_q == S_CAPTURE) begin
          if (!jump_i) begin
            instr_d = ir_i;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            state_d = S_OFFER;
          end
        end else if (xfer) begin
          // A transfer on the same edge as a jump still counts.
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          if (stop_pend_q || stop_i) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            // pc_o has been stable across the offer edge, so ir_i is already mem[pc_o].
            state_d = S_CAPTURE;
          end
        end
        // Redirect overrides normal sequencing; any open offer is dropped.
        if (jump_i) begin
          pc_d     = jump_addr_i;
          valid_d  = 1'b0;
          halted_d = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_HALTED: begin
        if (start_ok) begin
          halted_d    = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: reset/idle vector table, directed multi-cycle
// sequences (stall, jump drop, stop/resume, pc wrap, mid-offer reset) and a
// randomized run checked against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam int PW = 8;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          res_n;
  logic          run, stop, ready, jump;
  logic [PW-1:0] jaddr;
  logic [PW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] instr;
  logic          valid;
  logic          halted;
  logic [CW-1:0] cnt;

  logic [DW-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // Program_Mem: registered read of mem[pc]
  always_ff @(posedge clk) ir <= mem[pc];

  fetch_ctrl #(.PC_WIDTH(PW), .DataWidth(DW), .RESET_PC(8'd0), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .res_n         (res_n),
    .run_i         (run),
    .stop_i        (stop),
    .pc_o          (pc),
    .ir_i          (ir),
    .instr_o       (instr),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .jump_i        (jump),
    .jump_addr_i   (jaddr),
    .halted_o      (halted),
    .fetch_count_o (cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] epc, input bit ev,
                         input logic [15:0] einstr, input bit eh, input logic [15:0] ecnt);
    chk({tag, ".pc"}, 32'(pc), 32'(epc));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    if (ev) chk({tag, ".instr"}, 32'(instr), 32'(einstr));
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
    chk({tag, ".count"}, 32'(cnt), 32'(ecnt));
  endtask

  // driver tasks
  task automatic drive(input bit r, input bit s, input bit rd, input bit j, input logic [7:0] ja);
    run = r; stop = s; ready = rd; jump = j; jaddr = ja;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  // reference model: running/halted flags, address of the next fetch and
  // edges remaining until the next offer appears
  bit            m_active, m_halted, m_stop_pend, m_valid;
  int            m_wait;
  logic [7:0]    m_next;
  logic [15:0]   m_instr, m_cnt;

  task automatic model_reset();
    m_active = 0; m_halted = 0; m_stop_pend = 0; m_valid = 0;
    m_wait = 0; m_next = 8'd0; m_instr = 16'd0; m_cnt = 16'd0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit rd, input bit j, input logic [7:0] ja);
    bit x;
    if (!m_active) begin
      if (r && !s) begin
        m_active = 1; m_halted = 0; m_stop_pend = 0; m_wait = 2;
      end
    end else begin
      x = m_valid && rd;
      if (x) begin
        m_cnt++;
        m_valid = 0;
      end
      if (s) m_stop_pend = 1;
      if (j) begin
        m_next = ja; m_valid = 0; m_wait = 2;
      end else if (x) begin
        if (m_stop_pend) begin
          m_active = 0; m_halted = 1;
        end else begin
          m_wait = 1;
        end
      end else if (!m_valid) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1; m_instr = mem[m_next]; m_next = m_next + 8'd1;
        end
      end
    end
  endtask

  typedef struct {
    bit         run, stop, ready, jump;
    logic [7:0] jaddr;
    logic [7:0] pc;
    bit         valid;
    logic [15:0] instr;
    bit         halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h4903; mem[1]  = 16'h4A14; mem[2] = 16'h4BF0;
    mem[10] = 16'h8802; mem[13] = 16'h3902;

    // check outputs, then apply row inputs for the following edge
    tbl[0]  = '{0, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[1]  = '{0, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[2]  = '{0, 0, 1, 1, 8'h55, 8'd0, 0, 16'h0,    0, 16'd0}; // jump in IDLE ignored
    tbl[3]  = '{1, 1, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0}; // run+stop: stop wins
    tbl[4]  = '{0, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[5]  = '{1, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[6]  = '{0, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[7]  = '{0, 0, 1, 0, 8'h00, 8'd0, 0, 16'h0,    0, 16'd0};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 8'd1, 1, 16'h4903, 0, 16'd0};
    tbl[9]  = '{0, 0, 1, 0, 8'h00, 8'd1, 0, 16'h0,    0, 16'd1};
    tbl[10] = '{0, 0, 1, 0, 8'h00, 8'd2, 1, 16'h4A14, 0, 16'd1};
    tbl[11] = '{0, 0, 1, 0, 8'h00, 8'd2, 0, 16'h0,    0, 16'd2};
    tbl[12] = '{0, 0, 1, 0, 8'h00, 8'd3, 1, 16'h4BF0, 0, 16'd2};
    tbl[13] = '{0, 0, 0, 0, 8'h00, 8'd3, 0, 16'h0,    0, 16'd3};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].instr, tbl[i].halted, tbl[i].cnt);
      drive(tbl[i].run, tbl[i].stop, tbl[i].ready, tbl[i].jump, tbl[i].jaddr);
      @(negedge clk);
    end

    // stall: ready low for 4 cycles during offer of pc 1
    do_reset();
    drive(1, 0, 1, 0, 8'h00); @(negedge clk);
    drive(0, 0, 1, 0, 8'h00); @(negedge clk);
    @(negedge clk);
    chk_all("stall.o0", 8'd1, 1, 16'h4903, 0, 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("stall.hold%0d", i), 8'd2, 1, 16'h4A14, 0, 16'd1);
      @(negedge clk);
    end
    drive(0, 0, 1, 0, 8'h00);
    @(negedge clk);
    chk_all("stall.xfer", 8'd2, 0, 16'h0, 0, 16'd2);
    drive(0, 0, 0, 0, 8'h00);

    // jump drops an un-transferred offer
    do_reset();
    drive(1, 0, 0, 0, 8'h00); @(negedge clk);
    drive(0, 0, 0, 1, 8'd10); @(negedge clk);
    chk_all("jmp.load10", 8'd10, 0, 16'h0, 0, 16'd0);
    drive(0, 0, 0, 0, 8'h00); @(negedge clk);
    @(negedge clk);
    chk_all("jmp.offer10", 8'd11, 1, 16'h8802, 0, 16'd0);
    drive(0, 0, 0, 1, 8'd13); @(negedge clk);
    chk_all("jmp.drop", 8'd13, 0, 16'h0, 0, 16'd0);
    drive(0, 0, 0, 0, 8'h00); @(negedge clk);
    chk_all("jmp.capt", 8'd13, 0, 16'h0, 0, 16'd0);
    @(negedge clk);
    chk_all("jmp.target", 8'd14, 1, 16'h3902, 0, 16'd0);

    // stop in LOAD: one more transfer, then halt; resume at frozen pc
    drive(0, 0, 0, 1, 8'd20); @(negedge clk);
    chk_all("stop.load", 8'd20, 0, 16'h0, 0, 16'd0);
    drive(0, 1, 1, 0, 8'h00); @(negedge clk);
    chk_all("stop.capt", 8'd20, 0, 16'h0, 0, 16'd0);
    drive(0, 0, 1, 0, 8'h00); @(negedge clk);
    chk_all("stop.offer", 8'd21, 1, mem[20], 0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_all($sformatf("stop.halt%0d", i), 8'd21, 0, 16'h0, 1, 16'd1);
    end
    drive(1, 0, 1, 0, 8'h00); @(negedge clk);
    chk_all("stop.resume", 8'd21, 0, 16'h0, 0, 16'd1);
    drive(0, 0, 1, 0, 8'h00); @(negedge clk);
    @(negedge clk);
    chk_all("stop.refetch", 8'd22, 1, mem[21], 0, 16'd1);

    // jump to 255 together with a transfer, pc wraps after capture
    drive(0, 0, 1, 1, 8'hFF); @(negedge clk);
    chk_all("wrap.load", 8'hFF, 0, 16'h0, 0, 16'd2);
    drive(0, 0, 0, 0, 8'h00); @(negedge clk);
    @(negedge clk);
    chk_all("wrap.offer", 8'h00, 1, mem[255], 0, 16'd2);

    // asynchronous reset in the middle of an offer
    #2 res_n = 1'b0;
    #1;
    chk_all("areset", 8'd0, 0, 16'h0, 0, 16'd0);
    chk("areset.instr", 32'(instr), 32'd0);
    @(negedge clk);
    res_n = 1'b1;

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit r, s, rd, j;
      logic [7:0] ja;
      if (c == 1500) begin
        do_reset();
        model_reset();
      end
      chk_all($sformatf("rnd%0d", c), m_next, m_valid, m_instr, m_halted, m_cnt);
      r  = ($urandom_range(0, 2) == 0);
      s  = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 1) == 0);
      j  = ($urandom_range(0, 15) == 0);
      ja = 8'($urandom);
      drive(r, s, rd, j, ja);
      model_step(r, s, rd, j, ja);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
